branch_resolve_unit: RTL and testbench

Resolution-side partner of the 2-bit branch predictor. Records each fetched branch's prediction, PC and target in an in-order in-flight queue. When EX/MEM resolves the oldest branch, it compares outcome against prediction and drives the predictor's update/taken inputs. On a mispredict it also issues a pipeline flush and a redirect PC, and keeps saturating branch and mispredict statistics.

---
 rtl/branch_resolve_if.sv | 39 +++
 rtl/branch_resolve_unit.sv | 93 +++++++++
 tb/tb_branch_resolve_unit.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_if.sv
// Handshake bundle between the fetch/EX side and the branch resolve unit.
// master drives issue/resolve; slave (the unit) drives predictor updates, flush and stats.
interface branch_resolve_if #(
  parameter int PC_W  = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic             issue_valid;
  logic             issue_predict;
  logic [PC_W-1:0]  issue_pc;
  logic [PC_W-1:0]  issue_target;
  logic             issue_ready;
  logic             resolve_valid;
  logic             resolve_taken;
  logic             update;
  logic             taken;
  logic             flush;
  logic [PC_W-1:0]  redirect_pc;
  logic [OCC_W-1:0] inflight_count;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;
  logic             protocol_err;

  modport master (
    output issue_valid, issue_predict, issue_pc, issue_target,
    output resolve_valid, resolve_taken,
    input  issue_ready, update, taken, flush, redirect_pc,
    input  inflight_count, branch_count, mispredict_count, protocol_err
  );

  modport slave (
    input  issue_valid, issue_predict, issue_pc, issue_target,
    input  resolve_valid, resolve_taken,
    output issue_ready, update, taken, flush, redirect_pc,
    output inflight_count, branch_count, mispredict_count, protocol_err
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Tracks in-flight predicted branches in order and, when the oldest resolves,
// updates the 2-bit predictor and issues flush/redirect on a mispredict.
module branch_resolve_unit #(
  parameter int PC_W  = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input logic             clk,
  input logic             rst,
  branch_resolve_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic            pred_q [DEPTH];
  logic [PC_W-1:0] pc_q   [DEPTH];
  logic [PC_W-1:0] tgt_q  [DEPTH];

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [AW:0]      occ;
  logic             full, empty, push, pop, mis;
  logic [AW-1:0]    head;

  logic             update_p1, taken_p1, flush_p1, perr_q;
  logic [PC_W-1:0]  redirect_p1;
  logic [CNT_W-1:0] branch_cnt_q, mis_cnt_q;

  // Stage 0: queue occupancy and resolve decision on the head entry
  assign occ   = wr_ptr - rd_ptr;
  assign full  = (occ == (AW+1)'(DEPTH));
  assign empty = (occ == '0);
  assign head  = rd_ptr[AW-1:0];
  assign push  = bus.issue_valid & ~full;
  assign pop   = bus.resolve_valid & ~empty;
  assign mis   = pop & (pred_q[head] ^ bus.resolve_taken);

  always_ff @(posedge clk) begin
    if (push) begin
      pred_q[wr_ptr[AW-1:0]] <= bus.issue_predict;
      pc_q[wr_ptr[AW-1:0]]   <= bus.issue_pc;
      tgt_q[wr_ptr[AW-1:0]]  <= bus.issue_target;
    end
  end

  // A mispredict squashes every younger entry and any same-cycle push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (mis) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Stage 1: registered predictor update, flush/redirect and statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      update_p1    <= 1'b0;
      taken_p1     <= 1'b0;
      flush_p1     <= 1'b0;
      redirect_p1  <= '0;
      branch_cnt_q <= '0;
      mis_cnt_q    <= '0;
      perr_q       <= 1'b0;
    end else begin
      update_p1 <= pop;
      flush_p1  <= mis;
      if (pop) begin
        taken_p1     <= bus.resolve_taken;
        redirect_p1  <= bus.resolve_taken ? tgt_q[head] : pc_q[head] + PC_W'(4);
        branch_cnt_q <= sat_inc(branch_cnt_q);
      end
      if (mis) mis_cnt_q <= sat_inc(mis_cnt_q);
      if (bus.resolve_valid && empty) perr_q <= 1'b1;
    end
  end

  assign bus.issue_ready      = ~full;
  assign bus.update           = update_p1;
  assign bus.taken            = taken_p1;
  assign bus.flush            = flush_p1;
  assign bus.redirect_pc      = redirect_p1;
  assign bus.inflight_count   = occ;
  assign bus.branch_count     = branch_cnt_q;
  assign bus.mispredict_count = mis_cnt_q;
  assign bus.protocol_err     = perr_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios plus randomized traffic checked
// every cycle against a queue-based reference model; a CNT_W=2 twin shares the stimulus.
module tb_branch_resolve_unit;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_resolve_if #(.PC_W(32), .DEPTH(DEPTH), .CNT_W(16)) bus1 ();
  branch_resolve_if #(.PC_W(32), .DEPTH(DEPTH), .CNT_W(2))  bus2 ();

  branch_resolve_unit #(.PC_W(32), .DEPTH(DEPTH), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus1));
  branch_resolve_unit #(.PC_W(32), .DEPTH(DEPTH), .CNT_W(2))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

  assign bus2.issue_valid   = bus1.issue_valid;
  assign bus2.issue_predict = bus1.issue_predict;
  assign bus2.issue_pc      = bus1.issue_pc;
  assign bus2.issue_target  = bus1.issue_target;
  assign bus2.resolve_valid = bus1.resolve_valid;
  assign bus2.resolve_taken = bus1.resolve_taken;

  typedef struct {
    bit          p;
    logic [31:0] pc;
    logic [31:0] tgt;
  } ent_t;

  ent_t        mq[$];
  bit          m_update, m_taken, m_flush, m_perr;
  logic [31:0] m_redirect;
  longint      raw_br, raw_mis;
  int          n_cmp = 0;
  int          n_fail = 0;
  bit          chk_en = 1'b1;

  function automatic longint sat(input longint raw, input int w);
    longint mx = (longint'(1) << w) - 1;
    return (raw > mx) ? mx : raw;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_update = 0; m_taken = 0; m_flush = 0; m_perr = 0;
    m_redirect = '0; raw_br = 0; raw_mis = 0;
  endtask

  // Next-state of the model for one rising edge with the given inputs.
  task automatic model_step(input bit iv, input bit ip, input logic [31:0] pc,
                            input logic [31:0] tgt, input bit rv, input bit rt);
    bit   accept = iv && (mq.size() < DEPTH);
    bit   mis = 0;
    ent_t e;
    m_update = 0;
    m_flush  = 0;
    if (rv && mq.size() > 0) begin
      e = mq.pop_front();
      mis = e.p ^ rt;
      m_update = 1;
      m_taken = rt;
      m_flush = mis;
      m_redirect = rt ? e.tgt : e.pc + 32'd4;
      raw_br++;
      if (mis) begin
        raw_mis++;
        mq.delete();
      end
    end else if (rv) begin
      m_perr = 1;
    end
    if (accept && !mis) begin
      e.p = ip; e.pc = pc; e.tgt = tgt;
      mq.push_back(e);
    end
  endtask

  task automatic drive(input bit iv, input bit ip, input logic [31:0] pc,
                       input logic [31:0] tgt, input bit rv, input bit rt);
    bus1.issue_valid = iv; bus1.issue_predict = ip;
    bus1.issue_pc = pc; bus1.issue_target = tgt;
    bus1.resolve_valid = rv; bus1.resolve_taken = rt;
  endtask

  task automatic cycle(input bit iv, input bit ip, input logic [31:0] pc,
                       input logic [31:0] tgt, input bit rv, input bit rt);
    @(negedge clk);
    drive(iv, ip, pc, tgt, rv, rt);
    model_step(iv, ip, pc, tgt, rv, rt);
  endtask

  task automatic settle();
    @(posedge clk);
    #3;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, '0, '0, 0, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    model_step(0, 0, '0, '0, 0, 0);
  endtask

  // Per-cycle comparison of both DUTs against the model.
  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      chk("issue_ready", 64'(bus1.issue_ready), 64'(mq.size() < DEPTH));
      chk("inflight_count", 64'(bus1.inflight_count), 64'(mq.size()));
      chk("update", 64'(bus1.update), 64'(m_update));
      chk("taken", 64'(bus1.taken), 64'(m_taken));
      chk("flush", 64'(bus1.flush), 64'(m_flush));
      chk("redirect_pc", 64'(bus1.redirect_pc), 64'(m_redirect));
      chk("branch_count", 64'(bus1.branch_count), 64'(sat(raw_br, 16)));
      chk("mispredict_count", 64'(bus1.mispredict_count), 64'(sat(raw_mis, 16)));
      chk("protocol_err", 64'(bus1.protocol_err), 64'(m_perr));
      chk("branch_count_w2", 64'(bus2.branch_count), 64'(sat(raw_br, 2)));
      chk("mispredict_count_w2", 64'(bus2.mispredict_count), 64'(sat(raw_mis, 2)));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp_redir [5];
    drive(0, 0, '0, '0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_step(0, 0, '0, '0, 0, 0);

    // Mispredicted not-taken branch
    do_reset();
    cycle(1, 0, 32'h100, 32'h200, 0, 0);
    cycle(0, 0, '0, '0, 1, 1);
    settle();
    chk("t1_update", 64'(bus1.update), 64'd1);
    chk("t1_taken", 64'(bus1.taken), 64'd1);
    chk("t1_flush", 64'(bus1.flush), 64'd1);
    chk("t1_redirect", 64'(bus1.redirect_pc), 64'h200);
    chk("t1_miscnt", 64'(bus1.mispredict_count), 64'd1);
    chk("t1_occ", 64'(bus1.inflight_count), 64'd0);
    cycle(0, 0, '0, '0, 0, 0);
    settle();
    chk("t1_update_drop", 64'(bus1.update), 64'd0);
    chk("t1_flush_drop", 64'(bus1.flush), 64'd0);
    chk("t1_taken_hold", 64'(bus1.taken), 64'd1);

    // Correct taken prediction
    do_reset();
    cycle(1, 1, 32'h40, 32'h80, 0, 0);
    cycle(0, 0, '0, '0, 1, 1);
    settle();
    chk("t2_update", 64'(bus1.update), 64'd1);
    chk("t2_flush", 64'(bus1.flush), 64'd0);
    chk("t2_brcnt", 64'(bus1.branch_count), 64'd1);
    chk("t2_miscnt", 64'(bus1.mispredict_count), 64'd0);

    // Fill, overflow drop, FIFO drain with pc+4 redirects
    do_reset();
    for (int i = 1; i <= 4; i++) cycle(1, 0, 32'(i * 16), 32'h1000, 0, 0);
    settle();
    chk("t3_ready_full", 64'(bus1.issue_ready), 64'd0);
    chk("t3_occ_full", 64'(bus1.inflight_count), 64'd4);
    cycle(1, 0, 32'h50, 32'h1000, 0, 0);
    settle();
    chk("t3_drop_occ", 64'(bus1.inflight_count), 64'd4);
    cycle(0, 0, '0, '0, 1, 0);
    settle();
    chk("t3_occ_pop", 64'(bus1.inflight_count), 64'd3);
    exp_redir[0] = 32'h14; exp_redir[1] = 32'h24; exp_redir[2] = 32'h34;
    exp_redir[3] = 32'h44; exp_redir[4] = 32'h64;
    chk("t3_redir0", 64'(bus1.redirect_pc), 64'(exp_redir[0]));
    cycle(1, 0, 32'h60, 32'h1000, 1, 0);
    settle();
    chk("t3_occ_same", 64'(bus1.inflight_count), 64'd3);
    chk("t3_redir1", 64'(bus1.redirect_pc), 64'(exp_redir[1]));
    for (int i = 2; i < 5; i++) begin
      cycle(0, 0, '0, '0, 1, 0);
      settle();
      chk("t3_redir_drain", 64'(bus1.redirect_pc), 64'(exp_redir[i]));
    end
    chk("t3_empty", 64'(bus1.inflight_count), 64'd0);

    // Mispredict squashes queue and same-cycle push; then empty resolve
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1, 1, 32'h300 + 32'(i * 4), 32'h900, 0, 0);
    cycle(1, 1, 32'h500, 32'h900, 1, 0);
    settle();
    chk("t4_flush", 64'(bus1.flush), 64'd1);
    chk("t4_redirect", 64'(bus1.redirect_pc), 64'h304);
    chk("t4_occ", 64'(bus1.inflight_count), 64'd0);
    cycle(0, 0, '0, '0, 1, 0);
    settle();
    chk("t4_perr", 64'(bus1.protocol_err), 64'd1);
    chk("t4_no_update", 64'(bus1.update), 64'd0);

    // Asynchronous reset in the middle of traffic
    do_reset();
    cycle(1, 0, 32'hFFFF_FFFC, 32'h10, 0, 0);
    cycle(1, 1, 32'h600, 32'h610, 1, 0);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, '0, '0, 0, 0);
    model_reset();
    #1;
    chk("t5_occ", 64'(bus1.inflight_count), 64'd0);
    chk("t5_ready", 64'(bus1.issue_ready), 64'd1);
    chk("t5_redirect", 64'(bus1.redirect_pc), 64'd0);
    chk("t5_brcnt", 64'(bus1.branch_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    model_step(0, 0, '0, '0, 0, 0);
    cycle(1, 0, 32'hFFFF_FFFC, 32'h900, 0, 0);
    cycle(0, 0, '0, '0, 1, 0);
    settle();
    chk("t5_wrap_redirect", 64'(bus1.redirect_pc), 64'd0);
    chk("t5_after_brcnt", 64'(bus1.branch_count), 64'd1);

    // Counter saturation on the narrow instance
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 32'(i * 256), 32'h4000, 0, 0);
      cycle(0, 0, '0, '0, 1, 1);
    end
    cycle(0, 0, '0, '0, 0, 0);
    settle();
    chk("t6_miscnt16", 64'(bus1.mispredict_count), 64'd5);
    chk("t6_miscnt2", 64'(bus2.mispredict_count), 64'd3);
    chk("t6_brcnt2", 64'(bus2.branch_count), 64'd3);

    // Randomized traffic in phases of varying issue/resolve density
    do_reset();
    for (int ph = 0; ph < 15; ph++) begin
      int ip_pct = $urandom_range(20, 95);
      int rv_pct = $urandom_range(10, 90);
      for (int c = 0; c < 200; c++) begin
        logic [31:0] pc;
        pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
        cycle(($urandom_range(0, 99) < ip_pct), 1'($urandom), pc, $urandom,
              ($urandom_range(0, 99) < rv_pct), 1'($urandom));
      end
    end
    cycle(0, 0, '0, '0, 0, 0);
    settle();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
